uart_cfg_ctrl: RTL and testbench
================================

UART_CFG_CTRL -- requirements
Module: uart_cfg_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: max idle cycles between command bytes before abort.
REQ-002 Parameter SETTLE_CYCLES, default 16: cycles baud_ready is held low after a baud change.
REQ-003 clk_16bd  input  1  single clock (16x baud); all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 frame  input  9  received frame from the UART receiver; bits [7:0] are the byte.
REQ-006 frame_valid  input  1  frame good flag; a byte is accepted on its 0->1 edge only.
REQ-007 baud  output  3  baud select to the clock handler.
REQ-008 baud_ready  output  1  baud select stable qualifier.
REQ-009 parity, parity_type, stop_bits  output  1 each  receiver format controls.
REQ-010 frame_length  output  4  receiver data bit count.
REQ-011 data_out  output  8  pass-through payload byte.
REQ-012 data_valid  output  1  one-cycle strobe for data_out.
REQ-013 cfg_err  output  1  one-cycle strobe on a rejected command.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Byte event = registered rising edge of frame_valid; a level held high yields exactly one event.
REQ-016 FSM states: IDLE, CMD, ARG, CHK, APPLY, SETTLE.
REQ-017 IDLE: byte 0xA5 -> CMD. Any other byte -> data_out=byte, data_valid=1 one cycle after the event, state stays IDLE.
REQ-018 CMD: byte latched as command -> ARG. 0x03 (defaults) also goes to ARG; its argument is ignored.
REQ-019 ARG: byte latched as argument -> CHK if UART_CFG_CHECKSUM_EN is defined, else APPLY.
REQ-020 APPLY: one cycle. Decode command:
- 0x01: baud <= arg[2:0].
- 0x02: parity <= arg[0], parity_type <= arg[1], stop_bits <= arg[2], frame_length <= arg[7:4].
- 0x03: all format outputs return to reset values.
REQ-021 Command 0x02 with arg[7:4] outside 5..9, or any command other than 0x01/0x02/0x03: no output changes, cfg_err pulses, next state IDLE.
REQ-022 After a successful APPLY, next state is SETTLE if baud changed value, otherwise IDLE.
REQ-023 SETTLE: baud_ready=0 for exactly SETTLE_CYCLES cycles, then baud_ready=1, then IDLE. Baud changes in the same cycle baud_ready falls.
REQ-024 Byte events in APPLY or SETTLE are dropped silently.
REQ-025 In CMD, ARG, CHK, a timeout counter counts cycles without a byte event and clears on each event. On reaching TIMEOUT_CYCLES: cfg_err pulse, return to IDLE, no output change.
REQ-026 0xA5 received in CMD is treated as a command code and rejected per REQ-021. Payload byte 0xA5 can never pass through.
REQ-027 Format outputs change only in APPLY. They are never glitched or partially updated.

Reset
REQ-028 rst=0 at a clk_16bd edge: state IDLE, counters 0, and the following outputs:
- baud=3'b010, baud_ready=1
- parity=1, parity_type=0, stop_bits=0, frame_length=4'b1000
- data_out=0, data_valid=0, cfg_err=0, busy=0
REQ-029 Reset mid-command or mid-SETTLE aborts without a cfg_err pulse. The edge-detect register clears to 0, so a frame_valid high during reset produces an event after release.

Configuration
REQ-030 Macro UART_CFG_CHECKSUM_EN. When defined, CHK state accepts one byte that must equal 0xA5 ^ cmd ^ arg; on mismatch cfg_err pulses and the FSM returns to IDLE without applying. When undefined, the CHK state and its logic are absent and the command length is 3 bytes.

Verification
REQ-031 Bytes 0x41, 0x42 in IDLE -> data_valid pulses with data_out 0x41 then 0x42; format outputs unchanged.
REQ-032 Sequence 0xA5, 0x02, 0x76 (+ checksum 0xD1 if enabled) -> parity=0, parity_type=1, stop_bits=1, frame_length=7; baud_ready stays 1; no data_valid.
REQ-033 Sequence 0xA5, 0x01, 0x04 (+ 0xA0) -> baud=3'b100, baud_ready low for exactly 16 cycles; bytes sent during SETTLE are dropped.
REQ-034 Rejects, each -> one cfg_err pulse and no output change:
- 0xA5, 0x02, 0xA1 (frame_length 10)
- 0xA5, 0x07, 0x00
- with the checksum macro, 0xA5, 0x01, 0x04, 0x00 (bad checksum)
REQ-035 0xA5 followed by silence for 4096 cycles -> cfg_err pulse, busy falls; the next 0x33 passes through as data.
REQ-036 0xA5, 0x03, 0x00 after non-default settings -> all outputs at reset values; rst=0 asserted mid-sequence -> IDLE, no cfg_err.

Source files
------------

// File: rtl/uart_cfg_ctrl_if.sv
// Bus bundle between the UART receiver/clock handler side and uart_cfg_ctrl.
// The slave modport is the controller's own view. The master modport is the driving side's view.
interface uart_cfg_ctrl_if;
  logic [8:0] frame;
  logic       frame_valid;
  logic [2:0] baud;
  logic       baud_ready;
  logic       parity;
  logic       parity_type;
  logic       stop_bits;
  logic [3:0] frame_length;
  logic [7:0] data_out;
  logic       data_valid;
  logic       cfg_err;
  logic       busy;

  modport master (
    output frame, frame_valid,
    input  baud, baud_ready, parity, parity_type, stop_bits, frame_length,
    input  data_out, data_valid, cfg_err, busy
  );

  modport slave (
    input  frame, frame_valid,
    output baud, baud_ready, parity, parity_type, stop_bits, frame_length,
    output data_out, data_valid, cfg_err, busy
  );
endinterface

// File: rtl/uart_cfg_ctrl.sv
// In-band UART configuration: 0xA5 <cmd> <arg> [<chk>] reprograms baud/format; other bytes pass through.
// Optional macro UART_CFG_CHECKSUM_EN adds the checksum byte (0xA5 ^ cmd ^ arg).
module uart_cfg_ctrl #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SETTLE_CYCLES  = 16
) (
  input logic           clk_16bd,
  input logic           rst,
  uart_cfg_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [7:0] SYNC     = 8'hA5;
  localparam logic [2:0] BAUD_RST = 3'b010;

  typedef enum logic [2:0] {
    IDLE, CMD, ARG,
`ifdef UART_CFG_CHECKSUM_EN
    CHK,
`endif
    APPLY, SETTLE
  } state_t;

  state_t        state;
  logic          fv_q;
  logic [7:0]    cmd, arg;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] st_cnt;
  logic          evt, timed_out, flen_ok;
  logic [7:0]    byte_in;
  logic          frame_unused;

  assign byte_in      = bus.frame[7:0];
  assign frame_unused = bus.frame[8];
  assign evt          = bus.frame_valid & ~fv_q;
  assign timed_out    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign flen_ok      = (arg[7:4] >= 4'd5) && (arg[7:4] <= 4'd9);

  always_ff @(posedge clk_16bd) begin
    if (!rst) begin
      state            <= IDLE;
      fv_q             <= 1'b0;
      cmd              <= '0;
      arg              <= '0;
      tmo_cnt          <= '0;
      st_cnt           <= '0;
      bus.baud         <= BAUD_RST;
      bus.baud_ready   <= 1'b1;
      bus.parity       <= 1'b1;
      bus.parity_type  <= 1'b0;
      bus.stop_bits    <= 1'b0;
      bus.frame_length <= 4'b1000;
      bus.data_out     <= '0;
      bus.data_valid   <= 1'b0;
      bus.cfg_err      <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      fv_q           <= bus.frame_valid;
      bus.data_valid <= 1'b0;
      bus.cfg_err    <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (evt) begin
            if (byte_in == SYNC) begin
              state    <= CMD;
              bus.busy <= 1'b1;
            end else begin
              bus.data_out   <= byte_in;
              bus.data_valid <= 1'b1;
            end
          end
        end
        CMD: begin
          if (evt) begin
            cmd     <= byte_in;
            tmo_cnt <= '0;
            state   <= ARG;
          end else if (timed_out) begin
            bus.cfg_err <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        end
        ARG: begin
          if (evt) begin
            arg     <= byte_in;
            tmo_cnt <= '0;
`ifdef UART_CFG_CHECKSUM_EN
            state   <= CHK;
`else
            state   <= APPLY;
`endif
          end else if (timed_out) begin
            bus.cfg_err <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        end
`ifdef UART_CFG_CHECKSUM_EN
        CHK: begin
          if (evt) begin
            tmo_cnt <= '0;
            if (byte_in == (SYNC ^ cmd ^ arg)) state <= APPLY;
            else begin
              bus.cfg_err <= 1'b1;
              bus.busy    <= 1'b0;
              state       <= IDLE;
            end
          end else if (timed_out) begin
            bus.cfg_err <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        end
`endif
        APPLY: begin
          // baud and baud_ready move on the same edge so the clock handler never sees a stale-but-ready select
          st_cnt <= '0;
          case (cmd)
            8'h01: begin
              bus.baud <= arg[2:0];
              if (arg[2:0] != bus.baud) begin
                bus.baud_ready <= 1'b0;
                state          <= SETTLE;
              end else begin
                bus.busy <= 1'b0;
                state    <= IDLE;
              end
            end
            8'h02: begin
              if (flen_ok) begin
                bus.parity       <= arg[0];
                bus.parity_type  <= arg[1];
                bus.stop_bits    <= arg[2];
                bus.frame_length <= arg[7:4];
              end else bus.cfg_err <= 1'b1;
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
            8'h03: begin
              bus.baud         <= BAUD_RST;
              bus.parity       <= 1'b1;
              bus.parity_type  <= 1'b0;
              bus.stop_bits    <= 1'b0;
              bus.frame_length <= 4'b1000;
              if (bus.baud != BAUD_RST) begin
                bus.baud_ready <= 1'b0;
                state          <= SETTLE;
              end else begin
                bus.busy <= 1'b0;
                state    <= IDLE;
              end
            end
            default: begin
              bus.cfg_err <= 1'b1;
              bus.busy    <= 1'b0;
              state       <= IDLE;
            end
          endcase
        end
        SETTLE: begin
          if (st_cnt == SW'(SETTLE_CYCLES - 1)) begin
            bus.baud_ready <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end else st_cnt <= st_cnt + 1'b1;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Directed plus randomized bench for uart_cfg_ctrl against a command-level reference model.
module tb_uart_cfg_ctrl;
  localparam int T = 4096;
  localparam int S = 16;
`ifdef UART_CFG_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] baud;
    logic       parity;
    logic       ptype;
    logic       stop;
    logic [3:0] flen;
  } cfg_t;
  localparam cfg_t CFG_RST = '{3'b010, 1'b1, 1'b0, 1'b0, 4'h8};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_cfg_ctrl_if bus ();
  uart_cfg_ctrl #(.TIMEOUT_CYCLES(T), .SETTLE_CYCLES(S)) dut (
    .clk_16bd(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int err_cnt = 0, runs = 0, run = 0, last_run = 0;
  logic [7:0] dq[$];
  cfg_t exp_cfg;

  // observation side: payload strobes, error strobes, baud_ready low-run lengths
  always @(negedge clk) begin
    if (bus.data_valid) dq.push_back(bus.data_out);
    if (bus.cfg_err) err_cnt <= err_cnt + 1;
    if (!bus.baud_ready) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      runs     <= runs + 1;
      run      <= 0;
    end
  end

  function automatic cfg_t obs_cfg();
    return '{bus.baud, bus.parity, bus.parity_type, bus.stop_bits, bus.frame_length};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_cmd(input cfg_t cur, input logic [7:0] c, input logic [7:0] a,
                                    input bit bad, output cfg_t nxt, output bit err, output bit settle);
    nxt = cur;
    err = 1'b0;
    if (bad && CK_EN) err = 1'b1;
    else begin
      case (c)
        8'h01: nxt.baud = a[2:0];
        8'h02: if (a[7:4] >= 5 && a[7:4] <= 9) begin
                 nxt.parity = a[0]; nxt.ptype = a[1]; nxt.stop = a[2]; nxt.flen = a[7:4];
               end else err = 1'b1;
        8'h03: nxt = CFG_RST;
        default: err = 1'b1;
      endcase
    end
    settle = !err && (nxt.baud != cur.baud);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    bus.frame = {1'($urandom_range(0, 1)), b};
    bus.frame_valid = 1'b1;
    repeat (hold) @(negedge clk);
    bus.frame_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [7:0] a, input bit bad);
    logic [7:0] ck;
    ck = 8'hA5 ^ c ^ a;
    if (bad) ck = ck ^ 8'hA0;
    send_byte(8'hA5, 1);
    send_byte(c, 1);
    send_byte(a, 1);
    if (CK_EN) send_byte(ck, 1);
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] c, input logic [7:0] a,
                         input bit bad, input bit drop);
    cfg_t nxt;
    bit err, settle;
    int e0, d0, r0;
    e0 = err_cnt; d0 = dq.size(); r0 = runs;
    model_cmd(exp_cfg, c, a, bad, nxt, err, settle);
    send_hdr(c, a, bad);
    if (drop) begin
      send_byte(8'h5A, 1);
      send_byte(8'h3C, 2);
    end
    repeat (S + 12) @(negedge clk);
    check({tag, ".cfg"}, obs_cfg(), nxt);
    check({tag, ".cfg_err"}, err_cnt - e0, {31'd0, err});
    check({tag, ".data_valid"}, dq.size() - d0, 0);
    check({tag, ".settle_runs"}, runs - r0, {31'd0, settle});
    if (settle) check({tag, ".settle_len"}, last_run, S);
    check({tag, ".idle"}, {bus.busy, bus.baud_ready}, 2'b01);
    exp_cfg = nxt;
  endtask

  task automatic run_data(input string tag, input logic [7:0] b, input int hold);
    int e0, d0;
    e0 = err_cnt; d0 = dq.size();
    send_byte(b, hold);
    repeat (3) @(negedge clk);
    check({tag, ".dv_count"}, dq.size() - d0, 1);
    if (dq.size() > d0) check({tag, ".data_out"}, dq[dq.size() - 1], b);
    check({tag, ".cfg"}, obs_cfg(), exp_cfg);
    check({tag, ".cfg_err"}, err_cnt - e0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_cfg = CFG_RST;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int e0, d0, waited;
    logic [7:0] c, a;
    bus.frame = '0;
    bus.frame_valid = 1'b0;
    exp_cfg = CFG_RST;
    repeat (3) @(negedge clk);
    check("rst.cfg", obs_cfg(), CFG_RST);
    check("rst.baud_ready", bus.baud_ready, 1);
    check("rst.strobes", {bus.data_out, bus.data_valid, bus.cfg_err, bus.busy}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_data("pass41", 8'h41, 1);
    run_data("pass42", 8'h42, 1);
    run_data("held_level", 8'h17, 6);
    run_cmd("fmt76", 8'h02, 8'h76, 1'b0, 1'b0);
    run_cmd("baud4", 8'h01, 8'h04, 1'b0, 1'b1);
    run_cmd("rej_flen10", 8'h02, 8'hA1, 1'b0, 1'b0);
    run_cmd("rej_cmd07", 8'h07, 8'h00, 1'b0, 1'b0);
    run_cmd("rej_cmdA5", 8'hA5, 8'h00, 1'b0, 1'b0);
    run_cmd("rej_ck", 8'h01, 8'h04, 1'b1, 1'b0);
    run_cmd("same_baud", 8'h01, 8'h04, 1'b0, 1'b0);

    // command timeout: nothing may happen early, then one cfg_err within a bounded window
    e0 = err_cnt;
    send_byte(8'hA5, 1);
    repeat (T - 12) @(negedge clk);
    check("tmo.early_err", err_cnt - e0, 0);
    check("tmo.busy_hold", bus.busy, 1);
    waited = 0;
    while (err_cnt == e0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    check("tmo.cfg_err", err_cnt - e0, 1);
    check("tmo.busy_fall", bus.busy, 0);
    check("tmo.cfg", obs_cfg(), exp_cfg);
    run_data("tmo.pass33", 8'h33, 1);

    run_cmd("fmt_nd", 8'h02, 8'h95, 1'b0, 1'b0);
    run_cmd("baud5", 8'h01, 8'h05, 1'b0, 1'b0);
    run_cmd("defaults", 8'h03, 8'h00, 1'b0, 1'b0);

    // reset in the middle of a command
    run_cmd("baud7", 8'h01, 8'h07, 1'b0, 1'b0);
    e0 = err_cnt;
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    do_reset();
    check("rst_mid.cfg", obs_cfg(), CFG_RST);
    check("rst_mid.busy", bus.busy, 0);
    check("rst_mid.cfg_err", err_cnt - e0, 0);

    // reset in the middle of SETTLE
    send_hdr(8'h01, 8'h06, 1'b0);
    repeat (4) @(negedge clk);
    e0 = err_cnt;
    do_reset();
    check("rst_settle.ready", {bus.baud_ready, bus.busy}, 2'b10);
    check("rst_settle.cfg", obs_cfg(), CFG_RST);
    check("rst_settle.cfg_err", err_cnt - e0, 0);

    // frame_valid high through reset gives one event after release
    d0 = dq.size();
    @(negedge clk);
    rst = 1'b0;
    bus.frame = 9'h05A;
    bus.frame_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    bus.frame_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("fv_thru_rst.count", dq.size() - d0, 1);
    if (dq.size() > d0) check("fv_thru_rst.data", dq[dq.size() - 1], 8'h5A);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: begin
          a = 8'($urandom_range(0, 255));
          if (a == 8'hA5) a = 8'h5A;
          run_data("rnd.data", a, int'($urandom_range(1, 3)));
        end
        1: run_cmd("rnd.baud", 8'h01, 8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0, 1'b0);
        2: run_cmd("rnd.fmt", 8'h02, 8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0, 1'b0);
        3: run_cmd("rnd.dflt", 8'h03, 8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0, 1'b0);
        default: begin
          c = 8'($urandom_range(0, 255));
          if (c >= 8'h01 && c <= 8'h03) c = 8'h80 | c;
          run_cmd("rnd.badcmd", c, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
